pdi_byte_packer: RTL
====================

Name: pdi_byte_packer

Overview:
Upstream feeder for the 32-bit lightweight Remus top level. Takes an 8-bit host byte stream with AD/message and last markers and packs it into 32-bit words. Buffers the words in a small FIFO and presents them on the pdi_data/pdi_valid/pdi_ready/ad_valid interface the top level consumes. Partial final words are zero-padded and carry a byte count so the mode controller can handle padding.

Parameters:
BUSWIDTH, 32, output word width in bits
BUSWIDTHBYTE, 4, bytes per output word (BUSWIDTH/8)
DEPTH, 2, output FIFO entries; power of 2, minimum 2

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_data  in  8  host byte
in_valid  in  1  in_data valid
in_ad  in  1  byte belongs to associated data (1) or message (0)
in_last  in  1  final byte of the current AD or message segment
in_ready  out  1  byte accepted when in_valid && in_ready
pdi_data  out  BUSWIDTH  packed word; first byte in [31:24]
pdi_valid  out  1  FIFO head valid
pdi_ready  in  1  consumer accepts head when pdi_valid && pdi_ready
ad_valid  out  1  head word is AD
pdi_bytes  out  3  valid bytes in head word, 1..4
pdi_last  out  1  head word ends a segment

Behaviour:
- Reset (async assert): accumulator empty, byte index 0, FIFO empty. pdi_valid=0, pdi_data=0, ad_valid=0, pdi_bytes=0, pdi_last=0, and in_ready=0 while rst is high.
- After reset deasserts, in_ready = (fifo_count < DEPTH) && !split_pending. This is combinational from registers only, never from in_valid.
- Accumulator: byte index i in 0..3. An accepted byte is written to bits [31-8i -: 8]. The first byte of a word latches the word's ad flag.
- Word close: a word closes on the accepted byte with i==3 or with in_last=1. It is pushed into the FIFO that same edge, with bytes=i+1 and last=in_last. Unfilled low bytes are 0. The index resets to 0.
- Type switch: if an accepted byte has in_ad != the latched ad flag and i>0:
  - the partial word is pushed with bytes=i and last=0;
  - the byte is held in a one-byte split register and split_pending=1, so in_ready=0 for that cycle;
  - the next cycle (FIFO not full) the held byte starts a new word and split_pending clears.
  - If the held byte also has in_last=1, it forms a 1-byte word with last=1.
- Latency: a closing byte accepted at edge n gives pdi_valid=1 after edge n if the FIFO was empty. No combinational path from in_* to pdi_*.
- FIFO: registered head outputs. Push and pop on the same edge are legal at any count, including count==DEPTH-1. Push is never attempted when count==DEPTH, because in_ready is low then.
- Pop on pdi_valid && pdi_ready. pdi_data, ad_valid, pdi_bytes and pdi_last must stay stable while pdi_valid && !pdi_ready.
- Empty: pdi_valid=0. Head fields show the last popped entry and are don't-care.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- in_valid with in_ready=0: no state change, and the byte must be held by the host.
- rst asserted mid-word or with the FIFO non-empty: all content is discarded immediately. No partial word is emitted after release.

Test Plan:
- Bytes 01..08, in_ad=1, in_last on 08, pdi_ready=1 -> two words: 01020304 (bytes=4, last=0, ad=1) then 05060708 (bytes=4, last=1, ad=1), each one cycle after its closing byte.
- Bytes AA BB CC BB AA, in_ad=0, last on 5th -> AABBCCBB (bytes=4, last=0) then AA000000 (bytes=1, last=1, ad=0).
- AD 11 22, then message 33 with no in_last between -> 11220000 (bytes=2, ad=1, last=0); in_ready=0 for one cycle; 33 then packs into the next message word.
- pdi_ready=0, DEPTH=2, stream 12 bytes -> in_ready drops after 8 bytes with count=2 and head stable. Raising pdi_ready for one cycle lets exactly one more word be accepted.
- FIFO at count 1 with simultaneous push and pop for 10 cycles -> count stays 1 and word order is preserved.
- Assert rst after 3 bytes of a word and with 1 word queued -> pdi_valid=0 and in_ready=0 immediately. After release, a fresh 4-byte stream yields exactly one word with no stale bytes.

Source files
------------

// File: rtl/pdi_byte_packer_if.sv
// Byte-in / word-out bus between the host, the packer and the Remus top level.
interface pdi_byte_packer_if #(
    parameter int unsigned BUSWIDTH = 32
);
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ad;
    logic                in_last;
    logic                in_ready;
    logic [BUSWIDTH-1:0] pdi_data;
    logic                pdi_valid;
    logic                pdi_ready;
    logic                ad_valid;
    logic [2:0]          pdi_bytes;
    logic                pdi_last;

    modport master (
        output in_data, in_valid, in_ad, in_last, pdi_ready,
        input  in_ready, pdi_data, pdi_valid, ad_valid, pdi_bytes, pdi_last
    );

    modport slave (
        input  in_data, in_valid, in_ad, in_last, pdi_ready,
        output in_ready, pdi_data, pdi_valid, ad_valid, pdi_bytes, pdi_last
    );
endinterface

// File: rtl/pdi_byte_packer.sv
// Packs an 8-bit AD/message byte stream into BUSWIDTH-bit words (first byte in the MSBs)
// and queues them in a small FIFO with ad/last/byte-count side information.
module pdi_byte_packer #(
    parameter int unsigned BUSWIDTH     = 32,
    parameter int unsigned BUSWIDTHBYTE = 4,
    parameter int unsigned DEPTH        = 2
) (
    input logic              clk,
    input logic              rst,
    pdi_byte_packer_if.slave bus
);
    localparam int unsigned IW = (BUSWIDTHBYTE > 1) ? $clog2(BUSWIDTHBYTE) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BUSWIDTHBYTE - 1);

    logic [BUSWIDTH-1:0] r_acc;
    logic [IW-1:0]       r_idx;
    logic                r_ad;

    logic                r_split_pending;
    logic [7:0]          r_split_data;
    logic                r_split_ad;
    logic                r_split_last;

    logic [BUSWIDTH-1:0] r_mem_data  [DEPTH];
    logic                r_mem_ad    [DEPTH];
    logic [2:0]          r_mem_bytes [DEPTH];
    logic                r_mem_last  [DEPTH];
    logic [PW-1:0]       r_wptr;
    logic [PW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;

    logic                w_not_full;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_pop;
    logic                w_switch;
    logic                w_release;
    logic [BUSWIDTH-1:0] w_merged;
    logic [BUSWIDTH-1:0] w_split_word;

    logic                w_push;
    logic [BUSWIDTH-1:0] w_push_data;
    logic                w_push_ad;
    logic [2:0]          w_push_bytes;
    logic                w_push_last;
    logic [BUSWIDTH-1:0] w_acc_next;
    logic [IW-1:0]       w_idx_next;
    logic                w_ad_next;

    assign w_not_full = (r_count < CW'(DEPTH));
    assign w_in_ready = !rst && w_not_full && !r_split_pending;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pop      = (r_count != '0) && bus.pdi_ready;
    assign w_switch   = w_accept && (r_idx != '0) && (bus.in_ad != r_ad);
    assign w_release  = r_split_pending && w_not_full;

    // r_acc is cleared whenever a word closes, so unfilled low bytes are already zero.
    always_comb begin
        w_merged = r_acc;
        for (int unsigned b = 0; b < BUSWIDTHBYTE; b++) begin
            if (r_idx == IW'(b)) begin
                w_merged[BUSWIDTH-1-8*b -: 8] = bus.in_data;
            end
        end
        w_split_word                  = '0;
        w_split_word[BUSWIDTH-1 -: 8] = r_split_data;
    end

    always_comb begin
        w_push       = 1'b0;
        w_push_data  = r_acc;
        w_push_ad    = r_ad;
        w_push_bytes = '0;
        w_push_last  = 1'b0;
        w_acc_next   = r_acc;
        w_idx_next   = r_idx;
        w_ad_next    = r_ad;

        if (w_release) begin
            if (r_split_last) begin
                w_push       = 1'b1;
                w_push_data  = w_split_word;
                w_push_ad    = r_split_ad;
                w_push_bytes = 3'd1;
                w_push_last  = 1'b1;
                w_acc_next   = '0;
                w_idx_next   = '0;
            end else begin
                w_acc_next = w_split_word;
                w_idx_next = IW'(1);
            end
            w_ad_next = r_split_ad;
        end else if (w_switch) begin
            w_push       = 1'b1;
            w_push_data  = r_acc;
            w_push_ad    = r_ad;
            w_push_bytes = 3'(r_idx);
            w_push_last  = 1'b0;
            w_acc_next   = '0;
            w_idx_next   = '0;
        end else if (w_accept) begin
            w_ad_next = (r_idx == '0) ? bus.in_ad : r_ad;
            if ((r_idx == LAST_IDX) || bus.in_last) begin
                w_push       = 1'b1;
                w_push_data  = w_merged;
                w_push_ad    = w_ad_next;
                w_push_bytes = 3'(r_idx) + 3'd1;
                w_push_last  = bus.in_last;
                w_acc_next   = '0;
                w_idx_next   = '0;
            end else begin
                w_acc_next = w_merged;
                w_idx_next = r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc           <= '0;
            r_idx           <= '0;
            r_ad            <= 1'b0;
            r_split_pending <= 1'b0;
            r_split_data    <= '0;
            r_split_ad      <= 1'b0;
            r_split_last    <= 1'b0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem_data[i]  <= '0;
                r_mem_ad[i]    <= 1'b0;
                r_mem_bytes[i] <= '0;
                r_mem_last[i]  <= 1'b0;
            end
        end else begin
            r_acc <= w_acc_next;
            r_idx <= w_idx_next;
            r_ad  <= w_ad_next;

            if (w_switch) begin
                r_split_pending <= 1'b1;
                r_split_data    <= bus.in_data;
                r_split_ad      <= bus.in_ad;
                r_split_last    <= bus.in_last;
            end else if (w_release) begin
                r_split_pending <= 1'b0;
            end

            if (w_push) begin
                r_mem_data[r_wptr]  <= w_push_data;
                r_mem_ad[r_wptr]    <= w_push_ad;
                r_mem_bytes[r_wptr] <= w_push_bytes;
                r_mem_last[r_wptr]  <= w_push_last;
                r_wptr              <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.pdi_valid = (r_count != '0);
    assign bus.pdi_data  = r_mem_data[r_rptr];
    assign bus.ad_valid  = r_mem_ad[r_rptr];
    assign bus.pdi_bytes = r_mem_bytes[r_rptr];
    assign bus.pdi_last  = r_mem_last[r_rptr];
endmodule
